// File: rtl/dmem_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | dmem_arbiter_if : core, DMA and data-memory signal bundle for dmem_arbiter   |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // core load/store path
  logic          core_rd;
  logic          core_wr;
  logic [1:0]    core_mode;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;

  // DMA / loader requester
  logic          dma_req;
  logic          dma_we;
  logic [1:0]    dma_mode;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  // data memory port
  logic          mem_rd;
  logic          mem_wr;
  logic [1:0]    mem_mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_rd, core_wr, core_mode, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dma_req, dma_we, dma_mode, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_rd, mem_wr, mem_mode, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_rd, core_wr, core_mode, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dma_req, dma_we, dma_mode, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_rd, mem_wr, mem_mode, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | dmem_arbiter : core-priority data-memory arbiter with forced DMA slots.      |
// | Optional ARB_STATS_EN adds stall/grant cycle counters. STARVE_LIM: 1..15.    |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]    stat_stall,
  output logic [31:0]    stat_dma
`endif
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [3:0] LIM      = 4'(STARVE_LIM);

  logic [1:0]    owner;
  logic          core_act;
  logic          force_dma;
  logic          gnt;
  logic          stall;
  logic          mem_rd_w;
  logic          mem_wr_w;
  logic [1:0]    mem_mode_w;
  logic [AW-1:0] mem_addr_w;
  logic [DW-1:0] mem_wdata_w;

  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [DW-1:0] dma_rdata_q,  dma_rdata_d;
  logic          dma_rvalid_q, dma_rvalid_d;

  always_comb begin
    core_act  = bus.core_rd | bus.core_wr;
    force_dma = bus.dma_req & (starve_cnt_q == LIM);
    owner     = OWN_NONE;
    if (bus.dma_req & (!core_act | force_dma)) begin
      owner = OWN_DMA;
    end else if (core_act) begin
      owner = OWN_CORE;
    end
  end

  // A simultaneous core read+write resolves to a write.
  always_comb begin
    mem_rd_w    = 1'b0;
    mem_wr_w    = 1'b0;
    mem_mode_w  = 2'b00;
    mem_addr_w  = {AW{1'b0}};
    mem_wdata_w = {DW{1'b0}};
    gnt         = 1'b0;
    stall       = 1'b0;
    case (owner)
      OWN_CORE: begin
        mem_rd_w    = bus.core_rd & ~bus.core_wr;
        mem_wr_w    = bus.core_wr;
        mem_mode_w  = bus.core_mode;
        mem_addr_w  = bus.core_addr;
        mem_wdata_w = bus.core_wdata;
      end
      OWN_DMA: begin
        mem_rd_w    = ~bus.dma_we;
        mem_wr_w    = bus.dma_we;
        mem_mode_w  = bus.dma_mode;
        mem_addr_w  = bus.dma_addr;
        mem_wdata_w = bus.dma_wdata;
        gnt         = 1'b1;
        stall       = core_act;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    bus.mem_rd     = mem_rd_w;
    bus.mem_wr     = mem_wr_w;
    bus.mem_mode   = mem_mode_w;
    bus.mem_addr   = mem_addr_w;
    bus.mem_wdata  = mem_wdata_w;
    bus.core_rdata = bus.mem_rdata;
    bus.core_stall = stall;
    bus.dma_gnt    = gnt;
    bus.dma_rdata  = dma_rdata_q;
    bus.dma_rvalid = dma_rvalid_q;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.dma_req || gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    dma_rdata_d  = dma_rdata_q;
    dma_rvalid_d = 1'b0;
    if (gnt && !bus.dma_we) begin
      dma_rdata_d  = bus.mem_rdata;
      dma_rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
      dma_rdata_q  <= {DW{1'b0}};
      dma_rvalid_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] stat_stall_q, stat_stall_d;
  logic [31:0] stat_dma_q,   stat_dma_d;

  always_comb begin
    stat_stall_d = stat_stall_q + {31'd0, stall};
    stat_dma_d   = stat_dma_q + {31'd0, gnt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_q <= 32'd0;
      stat_dma_q   <= 32'd0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_dma_q   <= stat_dma_d;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_dma   = stat_dma_q;
`endif

endmodule

`default_nettype wire
